// File: rtl/wbs_mem.sv
// wbs_mem: pipelined Wishbone B4 responder over a byte-writable word RAM with tunable ack latency and stall
module wbs_mem #(
  parameter int ADDR_BITS = 10,
  parameter int ACK_LATENCY = 1,
  parameter int STALL_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  input  logic        wb_cyc_i,
  output logic        wb_stall_o
);
  logic [31:0] mem_q [1 << ADDR_BITS];
  logic [ADDR_BITS-1:0] idx;
  logic acc;
  logic unused_adr;
  logic [3:0] stall_q, stall_d;
  logic [ACK_LATENCY-1:0] vld_q, vld_d;
  logic [31:0] dat_q [ACK_LATENCY];
  logic [31:0] dat_d [ACK_LATENCY];

  assign idx = wb_adr_i[ADDR_BITS+1:2];
  assign unused_adr = ^{wb_adr_i[31:ADDR_BITS+2], wb_adr_i[1:0]};
  assign acc = wb_cyc_i & wb_stb_i & ~wb_stall_o & ~rst_i;
  assign wb_stall_o = stall_q != 4'd0;
  assign wb_ack_o = vld_q[ACK_LATENCY-1] & wb_cyc_i;
  assign wb_dat_o = wb_ack_o ? dat_q[ACK_LATENCY-1] : 32'h0;

  always_comb begin
    stall_d = !wb_cyc_i ? 4'd0 : acc ? 4'(STALL_CYCLES) : stall_q - {3'd0, wb_stall_o};
    vld_d[0] = acc;
    dat_d[0] = wb_we_i ? 32'h0 : mem_q[idx];
    for (int i = 1; i < ACK_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1] & wb_cyc_i;
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= 4'd0;
      vld_q <= '0;
      dat_q <= '{default: 32'h0};
    end else begin
      stall_q <= stall_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc & wb_we_i)
      for (int b = 0; b < 4; b++)
        if (wb_sel_i[b]) mem_q[idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
  end
endmodule

// File: tb/tb_wbs_mem.sv
// tb_wbs_mem: randomized scoreboard bench for wbs_mem against a word-array reference model
module tb_wbs_mem;
  localparam int AB = 4;
  localparam int L = 3;
  localparam int S = 1;
  typedef struct {
    int due;
    logic [31:0] dat;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 1'b0;
  logic stb = 1'b0;
  logic we = 1'b0;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdat = 32'h0;
  logic [3:0] sel = 4'h0;
  logic [31:0] rdat;
  logic ack, stall;
  exp_t q[$];
  exp_t ent;
  logic [31:0] mem [1 << AB];
  int edge_n = 0;
  int next_ok = 0;
  int acc_cnt = 0;
  int ix;
  int errs = 0;
  int checks = 0;
  logic e_ack;
  logic [31:0] e_dat;

  wbs_mem #(.ADDR_BITS(AB), .ACK_LATENCY(L), .STALL_CYCLES(S)) dut (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
    .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_ack_o(ack), .wb_cyc_i(cyc),
    .wb_stall_o(stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (clk) edge_n++;
    if (rst) begin
      q.delete();
      next_ok = 0;
    end else begin
      while (q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
      if (!cyc) begin
        q.delete();
        next_ok = 0;
      end else if (stb && edge_n >= next_ok) begin
        ix = int'(adr[AB+1:2]);
        ent.due = edge_n + L - 1;
        ent.dat = we ? 32'h0 : mem[ix];
        if (we)
          for (int b = 0; b < 4; b++)
            if (sel[b]) mem[ix][8*b +: 8] = wdat[8*b +: 8];
        q.push_back(ent);
        next_ok = edge_n + S + 1;
        acc_cnt++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at edge %0d: got %h want %h", nm, edge_n, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    #1;
    e_ack = 1'b0;
    e_dat = 32'h0;
    if (q.size() > 0 && q[0].due == edge_n && cyc && !rst) begin
      e_ack = 1'b1;
      e_dat = q[0].dat;
    end
    chk("ack", {31'd0, ack}, {31'd0, e_ack});
    chk("dat", rdat, e_dat);
    chk("stall", {31'd0, stall}, {31'd0, edge_n + 1 < next_ok});
  end

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n0 = acc_cnt;
    int t = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    do begin
      @(negedge clk);
      t++;
    end while (acc_cnt == n0 && t < 40);
    if (acc_cnt == n0) begin
      $display("FAIL accept_timeout: got no acceptance want one within %0d cycles", t);
      $fatal(1);
    end
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    cyc = 1'b1;
    for (int i = 0; i < (1 << AB); i++) req(1'b1, 32'(i * 4), $urandom, 4'hF);
    req(1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
    req(1'b0, 32'h40, 32'h0, 4'h0);
    idle(L + 1);
    req(1'b1, 32'h10, 32'h11223344, 4'hF);
    req(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101);
    req(1'b0, 32'h10, 32'h0, 4'hF);
    idle(L + 1);
    for (int i = 0; i < 4; i++) req(1'b0, 32'(i * 4), 32'h0, 4'hF);
    idle(L + 1);
    req(1'b1, 32'h20, 32'h5, 4'hF);
    idle(1);
    cyc = 1'b0;
    idle(2);
    req(1'b0, 32'h20, 32'h0, 4'hF);
    idle(L + 1);
    req(1'b0, 32'h0, 32'h0, 4'hF);
    req(1'b0, 32'h4, 32'h0, 4'hF);
    #2 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(L + 3);
    repeat (300) begin
      if ($urandom_range(0, 19) == 0) begin
        cyc = 1'b0;
        idle($urandom_range(1, 2));
      end
      req(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(L + 3);
    cyc = 1'b0;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/wbs_mem.md
# wbs_mem

Pipelined Wishbone B4 responder backed by a word-addressed, byte-writable RAM. It is the target side of the bus that `lsm` drives, and it is used as the data-memory model in the `lsm` and core-level benches. Latency and stall behaviour are parameterised so that the benches can exercise `lsm` against slow and back-pressuring slaves.

## Interface
Parameters:
- `ADDR_BITS`, default 10: word-address width; memory depth is 2^ADDR_BITS 32-bit words.
- `ACK_LATENCY`, default 1: cycles from request acceptance to `wb_ack_o`. Legal range 1..8.
- `STALL_CYCLES`, default 0: cycles `wb_stall_o` is held high after each accepted request. Legal range 0..15.

Ports:
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `wb_adr_i` in 32: byte address.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data, valid only while `wb_ack_o` is high.
- `wb_we_i` in 1: 1 = write, 0 = read.
- `wb_sel_i` in 4: byte-lane enables; bit n covers `[8n+7:8n]`.
- `wb_stb_i` in 1: request strobe.
- `wb_ack_o` out 1: response, one cycle per accepted request.
- `wb_cyc_i` in 1: bus cycle in progress.
- `wb_stall_o` out 1: request cannot be accepted this cycle.

## Operation
- **Acceptance:** a request is accepted on a rising edge where `wb_cyc_i & wb_stb_i & ~wb_stall_o` is sampled high.
- **Addressing:** word index is `wb_adr_i[ADDR_BITS+1:2]`.
  - `wb_adr_i[1:0]` and the bits above `ADDR_BITS+1` are ignored; addresses alias modulo 4·2^ADDR_BITS bytes.
- **Write:** each lane with its `wb_sel_i` bit set is written on the acceptance edge; lanes with the bit clear keep their value. `wb_sel_i = 0` writes nothing but is still acknowledged.
- **Read:** returns the full 32-bit word regardless of `wb_sel_i`. The word is captured on the acceptance edge, so a read accepted after a write to the same word returns the new data.
- **Response delay line:** accepted requests enter a delay line `ACK_LATENCY` entries deep. Each entry holds a valid bit and data; read data is the captured word, write data is `32'h0`.
  - `wb_ack_o = out_valid & wb_cyc_i`.
  - `wb_dat_o` = entry data while `wb_ack_o` is high, `32'h0` otherwise.
- **Stall counter (4 bits):** loaded with `STALL_CYCLES` on each acceptance edge, otherwise decremented toward 0. `wb_stall_o = (stall_cnt != 0)`.
- **Abort:** on any edge where `wb_cyc_i` is sampled low, all delay-line valid bits and `stall_cnt` are cleared.
  - Pending acks are dropped and never issued.
  - Writes already committed remain in memory.
- **Ordering:** acks are issued strictly in acceptance order, at most one per cycle.
- **Reset:** memory contents are not reset and are undefined after power-up.

## Timing
- **Reset values:** `wb_ack_o = 0`, `wb_dat_o = 32'h0`, `wb_stall_o = 0`, all delay-line valids 0, `stall_cnt = 0`.
- **Reset mid-operation:** asserting `rst_i` clears everything immediately, without waiting for a clock edge; in-flight acks are lost.
- **Latency:** for a request accepted on edge k, `wb_ack_o` is high in the cycle following edge k+`ACK_LATENCY`−1. With `ACK_LATENCY = 1`, ack appears in the cycle right after acceptance.
- **Throughput:** with `STALL_CYCLES = 0`, `wb_stall_o` is never asserted; back-to-back requests are accepted every cycle and acked every cycle.
- **Throughput with stall:** with `STALL_CYCLES = S > 0`, at most one request is accepted per S+1 cycles; `wb_stall_o` is high in the S cycles following each acceptance.
- **Strobe while stalled:** `wb_stb_i` high while `wb_stall_o` is high is not accepted and has no side effect; the master holds the request.
- **Mixed traffic:** a new request may be accepted in the same cycle an older ack is presented.
- **Timing paths:** `wb_stall_o` is fully registered; `wb_ack_o` and `wb_dat_o` have a combinational path only from `wb_cyc_i`.

## Test plan
- **Write then read** (defaults): write `32'hDEADBEEF`, sel `4'hF`, to `0x40`, then read `0x40`.
  - Each ack appears 1 cycle after its acceptance.
  - Read returns `32'hDEADBEEF`.
- **Byte lanes:** write `32'h11223344` sel `4'hF`, then `32'hAABBCCDD` sel `4'b0101`, both to `0x10`; read `0x10`.
  - Read returns `32'h11BB33DD`.
- **Pipelined burst** (`ACK_LATENCY = 3`, `STALL_CYCLES = 0`): 4 back-to-back reads of preloaded words `0x0`..`0xC`.
  - `wb_stall_o` stays 0.
  - 4 consecutive acks start 3 cycles after the first acceptance, with data in address order.
- **Stall** (`STALL_CYCLES = 2`): `wb_stb_i` held high for 3 requests.
  - Acceptances occur every 3rd cycle; `wb_stall_o` is high for 2 cycles after each.
  - Exactly 3 acks are issued.
- **Abort** (`ACK_LATENCY = 4`): accept a write of `32'h5` to `0x20`, then drop `wb_cyc_i` 2 cycles later.
  - No ack is ever issued.
  - A later read of `0x20` returns `32'h5`.
- **Reset mid-burst:** assert `rst_i` asynchronously with 2 acks pending.
  - `wb_ack_o`, `wb_stall_o` and `wb_dat_o` go to 0 immediately.
  - After release, no stale ack appears.
